// File: rtl/bin2seg_multi.sv
// Sequential binary-to-BCD (double dabble, one bit per clock) driving DIGITS active-low 7-segment outputs.
// Optional leading-zero blanking is compiled in when BIN2SEG_LZ_BLANK_EN is defined.
module bin2seg_multi #(
  parameter int IN_W   = 6,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   display
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int DISP_W = 7 * DIGITS;
  localparam int CNT_W  = (IN_W > 2) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IN_W-1:0]     shift_q, shift_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                ovacc_q, ovacc_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [DISP_W-1:0]   disp_q, disp_d;

  logic [BCD_W-1:0]    bcd_adj;
  logic [DISP_W-1:0]   seg_img;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Add-3 correction applied to every BCD digit before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // Segment image of the finished conversion; dashes win over everything.
`ifdef BIN2SEG_LZ_BLANK_EN
  logic lead_zero;
  always_comb begin
    seg_img   = '1;
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead_zero = lead_zero & (bcd_q[4*i +: 4] == 4'd0);
      if (ovacc_q) begin
        seg_img[7*i +: 7] = 7'b0111111;
      end else if (lead_zero && (i > 0)) begin
        seg_img[7*i +: 7] = 7'b1111111;
      end else begin
        seg_img[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
      end
    end
  end
`else
  always_comb begin
    seg_img = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ovacc_q) begin
        seg_img[7*i +: 7] = 7'b0111111;
      end else begin
        seg_img[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
      end
    end
  end
`endif

  // Next-state logic; busy tracks the SHIFT state one edge late so it spans exactly IN_W cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    ovacc_d = ovacc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    disp_d  = disp_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          shift_d = value;
          bcd_d   = '0;
          ovacc_d = 1'b0;
          cnt_d   = CNT_LAST;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        busy_d  = 1'b1;
        bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[IN_W-1]};
        shift_d = {shift_q[IN_W-2:0], 1'b0};
        ovacc_d = ovacc_q | bcd_adj[BCD_W-1];
        if (cnt_q == '0) begin
          state_d = S_UPDATE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_UPDATE: begin
        disp_d  = seg_img;
        ovf_d   = ovacc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset blanks the display and aborts any conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      ovacc_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      ovacc_q <= ovacc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign display  = disp_q;

endmodule

// File: tb/tb_bin2seg_multi.sv
// Randomized self-checking bench for bin2seg_multi against a decimal-arithmetic reference model.
`timescale 1ns/1ps
module tb_bin2seg_multi;

  localparam int IN_W   = 7;
  localparam int DIGITS = 2;
  localparam int DW     = 7 * DIGITS;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [IN_W-1:0] value = '0;
  logic            busy, done, overflow;
  logic [DW-1:0]   display;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] shown = '1;
  logic          shown_ov = 1'b0;

  bin2seg_multi #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .value(value),
    .busy(busy), .done(done), .overflow(overflow), .display(display)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [DW-1:0] model_disp(input int v);
    logic [DW-1:0] r = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v >= pow10(DIGITS)) begin
        r[7*i +: 7] = 7'b0111111;
      end else begin
        r[7*i +: 7] = SEG_TAB[(v / pow10(i)) % 10];
`ifdef BIN2SEG_LZ_BLANK_EN
        if (i > 0 && v < pow10(i)) r[7*i +: 7] = 7'b1111111;
`endif
      end
    end
    return r;
  endfunction

  task automatic idle_check(input int cycles);
    int d = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done === 1'b1) d++;
    end
    check_eq("no_done_idle", 64'(d), 64'(0));
    check_eq("idle_display", 64'(display), 64'(shown));
    check_eq("idle_overflow", 64'(overflow), 64'(shown_ov));
  endtask

  // Starts a conversion in the current cycle (may be the done cycle of the previous one).
  task automatic run_conv(input int v, input bit pulse_mid);
    logic [DW-1:0] exp_d;
    logic exp_o;
    int n = 0;
    int bcnt = 0;
    bit held_ok = 1'b1;
    exp_d = model_disp(v);
    exp_o = (v >= pow10(DIGITS));
    start = 1'b1;
    value = IN_W'(v);
    @(posedge clk); #1;
    start = 1'b0;
    value = IN_W'($urandom);
    while (done !== 1'b1 && n < 4 * IN_W) begin
      start = (pulse_mid && n == 2) ? 1'b1 : 1'b0;
      if (start) value = IN_W'($urandom);
      @(posedge clk); #1;
      n++;
      if (busy === 1'b1) bcnt++;
      if (done !== 1'b1 && display !== shown) held_ok = 1'b0;
    end
    start = 1'b0;
    check_eq("latency", 64'(n), 64'(IN_W + 1));
    check_eq("busy_cycles", 64'(bcnt), 64'(IN_W));
    check_eq("display_held", 64'(held_ok), 64'(1));
    check_eq($sformatf("display_v%0d", v), 64'(display), 64'(exp_d));
    check_eq($sformatf("overflow_v%0d", v), 64'(overflow), 64'(exp_o));
    check_eq("busy_at_done", 64'(busy), 64'(0));
    shown = exp_d;
    shown_ov = exp_o;
  endtask

  task automatic reset_mid(input int v);
    start = 1'b1;
    value = IN_W'(v);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", 64'(busy), 64'(0));
    check_eq("rst_mid_display", 64'(display), 64'({DW{1'b1}}));
    check_eq("rst_mid_done", 64'(done), 64'(0));
    check_eq("rst_mid_overflow", 64'(overflow), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    shown = '1;
    shown_ov = 1'b0;
    idle_check(IN_W + 4);
  endtask

  initial begin
    #12;
    check_eq("rst_display", 64'(display), 64'({DW{1'b1}}));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_overflow", 64'(overflow), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(20);

    run_conv(59, 1'b0);
    run_conv(100, 1'b0);
    idle_check(3);
    run_conv(99, 1'b0);
    run_conv(7, 1'b0);
    run_conv(0, 1'b0);
    run_conv(127, 1'b0);
    run_conv(10, 1'b0);
    run_conv(45, 1'b1);
    idle_check(IN_W + 3);

    for (int i = 0; i < 30; i++) begin
      run_conv(int'($urandom_range(0, 2**IN_W - 1)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check(int'($urandom_range(IN_W + 2, IN_W + 4)));
    end
    idle_check(IN_W + 3);

    reset_mid(88);
    run_conv(42, 1'b0);
    reset_mid(int'($urandom_range(0, 2**IN_W - 1)));
    run_conv(int'($urandom_range(0, 2**IN_W - 1)), 1'b0);
    idle_check(IN_W + 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
